// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl: zeroes the RAM after reset, then arbitrates client reads/writes
// and buffers 1-cycle-latency read data in a 2-entry response FIFO.
module ram_port_ctrl #(
  parameter int SIZE  = 5,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [SIZE-1:0]  req_adr,
  input  logic [WIDTH-1:0] req_dat,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_dat,
  output logic             init_done,
  output logic             mem_sel,
  output logic             mem_we,
  output logic [SIZE-1:0]  mem_adr,
  output logic [WIDTH-1:0] mem_dat_i,
  input  logic [WIDTH-1:0] mem_dat_o
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t          state_q, state_d;
  logic [SIZE-1:0] cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic [1:0]      fcnt_q, fcnt_d;
  logic            rd_q, wr_q;
  logic [WIDTH-1:0] fifo_q [2];
  logic            run, clr, hs, pop, push;
  assign clr       = state_q == CLEAR;
  assign run       = ~rst & ~clr;
  assign rsp_valid = ~rst & (fcnt_q != 2'd0);
  assign rsp_dat   = rsp_valid ? fifo_q[rd_q] : '0;
  assign pop       = rsp_valid & rsp_ready;
  assign push      = pend_q;
  // Outstanding reads (buffered + in flight) may never exceed the FIFO depth.
  assign req_ready = run & ((3'(fcnt_q) + 3'(pend_q) - 3'(pop)) < 3'd2);
  assign hs        = req_valid & req_ready;
  assign init_done = run;
  assign mem_sel   = ~rst & (clr | hs);
  assign mem_we    = clr | req_we;
  assign mem_adr   = clr ? cnt_q : req_adr;
  assign mem_dat_i = clr ? '0 : req_dat;
  always_comb begin
    state_d = (clr && &cnt_q) ? RUN : state_q;
    cnt_d   = clr ? cnt_q + 1'b1 : cnt_q;
    pend_d  = hs & ~req_we;
    fcnt_d  = fcnt_q + 2'(push) - 2'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      fcnt_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      fcnt_q  <= fcnt_d;
      rd_q    <= rd_q ^ pop;
      wr_q    <= wr_q ^ push;
    end
  end
  always_ff @(posedge clk) if (push) fifo_q[wr_q] <= mem_dat_o;
endmodule

// File: tb/tb_ram_port_ctrl.sv
// tb_ram_port_ctrl: random and directed stimulus against a transaction-level
// model (golden memory plus queue of expected responses with ready times).
module tb_ram_port_ctrl;
  localparam int DEPTH = 32;
  logic        clk = 0, rst = 1, req_valid = 0, req_we = 0, rsp_ready = 0;
  logic [4:0]  req_adr = '0;
  logic [63:0] req_dat = '0;
  logic        req_ready, rsp_valid, init_done, mem_sel, mem_we;
  logic [63:0] rsp_dat, mem_dat_i, mem_dat_o;
  logic [4:0]  mem_adr;
  logic [63:0] ram [DEPTH];
  logic [67:0] act;
  int checks = 0, errors = 0;

  typedef struct {logic [63:0] d; int avail;} rsp_t;
  typedef struct {bit v; bit we; logic [4:0] a; logic [63:0] d; bit rr; bit chk; logic [63:0] exp;} stim_t;
  rsp_t        q[$];
  logic [63:0] golden [DEPTH];
  bit          run = 0;
  int          clr = 0, cyc = 0;

  ram_port_ctrl #(.SIZE(5), .WIDTH(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_dat(req_dat), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dat(rsp_dat), .init_done(init_done), .mem_sel(mem_sel), .mem_we(mem_we),
    .mem_adr(mem_adr), .mem_dat_i(mem_dat_i), .mem_dat_o(mem_dat_o));

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_sel) begin
    if (mem_we) ram[mem_adr] <= mem_dat_i;
    else mem_dat_o <= ram[mem_adr];
  end
  assign act = {init_done, req_ready, rsp_valid, rsp_dat, mem_sel};

  function automatic bit m_valid();
    return !rst && q.size() > 0 && q[0].avail <= cyc;
  endfunction
  function automatic bit m_pop();
    return m_valid() && rsp_ready;
  endfunction
  function automatic bit m_ready();
    return !rst && run && (int'(q.size()) - int'(m_pop())) < 2;
  endfunction
  function automatic logic [67:0] exp_vec();
    logic        v = m_valid();
    logic        r = m_ready();
    logic [63:0] d = '0;
    if (rst) return '0;
    if (v) d = q[0].d;
    return {run, r, v, d, run ? (req_valid & r) : 1'b1};
  endfunction

  task automatic drive(bit v, bit we, logic [4:0] a, logic [63:0] d, bit rr);
    req_valid = v; req_we = we; req_adr = a; req_dat = d; rsp_ready = rr;
    #1;
  endtask

  task automatic tick();
    bit          hs = req_valid && m_ready();
    bit          pop = m_pop();
    bit          we = req_we;
    logic [4:0]  a = req_adr;
    logic [63:0] d = req_dat;
    @(posedge clk); #1;
    cyc++;
    if (rst) begin
      q.delete(); run = 0; clr = 0;
    end else if (!run) begin
      clr++;
      if (clr == DEPTH) begin
        run = 1;
        foreach (golden[i]) golden[i] = '0;
      end
    end else begin
      if (pop) void'(q.pop_front());
      if (hs) begin
        if (we) golden[a] = d;
        else q.push_back('{golden[a], cyc + 1});
      end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 5'(i), 64'hFFFF, 1);
      checks++;
      if (act !== 68'd0) begin errors++; $display("FAIL reset_outputs i=%0d got %h exp 0", i, act); end
      tick();
    end
  endtask

  task automatic test_clear(int n);
    rst = 0;
    for (int k = 0; k < n; k++) begin
      drive(1, 0, 5'(k + 3), 64'hFF, 1);
      checks++;
      if ({mem_sel, mem_we, mem_adr, mem_dat_i, init_done, req_ready} !== {1'b1, 1'b1, 5'(k), 64'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL clear_write k=%0d got sel=%b we=%b adr=%0d dat=%h init=%b rdy=%b exp adr=%0d", k, mem_sel, mem_we, mem_adr, mem_dat_i, init_done, req_ready, k);
      end
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL clear_vec k=%0d got %h exp %h", k, act, exp_vec()); end
      tick();
    end
    if (n == DEPTH) begin
      drive(0, 0, 0, 0, 1);
      checks++;
      if ({init_done, req_ready, mem_sel} !== 3'b110) begin errors++; $display("FAIL init_done got init=%b rdy=%b sel=%b exp 1 1 0", init_done, req_ready, mem_sel); end
    end
  endtask

  task automatic test_directed();
    stim_t s [10] = '{
      '{1, 0, 5'd31, 64'd0, 0, 0, 64'd0}, '{0, 0, 5'd0, 64'd0, 0, 0, 64'd0},
      '{0, 0, 5'd0, 64'd0, 0, 1, 64'd0},  '{0, 0, 5'd0, 64'd0, 1, 1, 64'd0},
      '{1, 1, 5'd5, 64'hDEADBEEF_00000005, 1, 0, 64'd0}, '{1, 0, 5'd5, 64'd0, 0, 0, 64'd0},
      '{0, 0, 5'd0, 64'd0, 0, 0, 64'd0},  '{0, 0, 5'd0, 64'd0, 0, 1, 64'hDEADBEEF_00000005},
      '{0, 0, 5'd0, 64'd0, 1, 1, 64'hDEADBEEF_00000005}, '{0, 0, 5'd0, 64'd0, 1, 0, 64'd0}};
    foreach (s[i]) begin
      drive(s[i].v, s[i].we, s[i].a, s[i].d, s[i].rr);
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL directed_vec i=%0d got %h exp %h", i, act, exp_vec()); end
      if (s[i].chk) begin
        checks++;
        if ({rsp_valid, rsp_dat} !== {1'b1, s[i].exp}) begin errors++; $display("FAIL directed_rsp i=%0d got v=%b %h exp v=1 %h", i, rsp_valid, rsp_dat, s[i].exp); end
      end
      tick();
    end
  endtask

  task automatic test_same_addr();
    stim_t s [5] = '{
      '{1, 1, 5'd7, 64'hA5, 1, 0, 64'd0}, '{1, 0, 5'd7, 64'd0, 0, 0, 64'd0},
      '{0, 0, 5'd0, 64'd0, 0, 0, 64'd0},  '{0, 0, 5'd0, 64'd0, 0, 1, 64'hA5},
      '{0, 0, 5'd0, 64'd0, 1, 1, 64'hA5}};
    foreach (s[i]) begin
      drive(s[i].v, s[i].we, s[i].a, s[i].d, s[i].rr);
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL same_addr_vec i=%0d got %h exp %h", i, act, exp_vec()); end
      if (s[i].chk) begin
        checks++;
        if ({rsp_valid, rsp_dat} !== {1'b1, s[i].exp}) begin errors++; $display("FAIL same_addr_rsp i=%0d got v=%b %h exp v=1 %h", i, rsp_valid, rsp_dat, s[i].exp); end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 11; c++) begin
      bit          ev = c >= 6 && c <= 9;
      logic [63:0] ed = ev ? 64'((c - 5) * 17) : 64'd0;
      if (c < 4) drive(1, 1, 5'(c + 1), 64'((c + 1) * 17), 1);
      else if (c < 8) drive(1, 0, 5'(c - 3), 64'd0, 1);
      else drive(0, 0, 0, 0, 1);
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL b2b_vec c=%0d got %h exp %h", c, act, exp_vec()); end
      if (c >= 4 && c < 8) begin
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready c=%0d got %b exp 1", c, req_ready); end
      end
      checks++;
      if ({rsp_valid, rsp_dat} !== {ev, ed}) begin errors++; $display("FAIL b2b_rsp c=%0d got v=%b %h exp v=%b %h", c, rsp_valid, rsp_dat, ev, ed); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 5'(10 + i), 64'(256 + 10 + i), 0);
      tick();
    end
    for (int c = 0; c < 9; c++) begin
      bit          ev = c >= 2 && c <= 6;
      logic [63:0] ed = !ev ? 64'd0 : c <= 4 ? 64'h10A : c == 5 ? 64'h10B : 64'h10C;
      drive(c <= 4, 0, c == 0 ? 5'd10 : c == 1 ? 5'd11 : 5'd12, 64'd0, c >= 4);
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL bp_vec c=%0d got %h exp %h", c, act, exp_vec()); end
      if (c <= 4) begin
        checks++;
        if (req_ready !== (c != 2 && c != 3)) begin errors++; $display("FAIL bp_ready c=%0d got %b exp %b", c, req_ready, c != 2 && c != 3); end
      end
      checks++;
      if ({rsp_valid, rsp_dat} !== {ev, ed}) begin errors++; $display("FAIL bp_rsp c=%0d got v=%b %h exp v=%b %h", c, rsp_valid, rsp_dat, ev, ed); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, DEPTH - 1)),
            {$urandom, $urandom}, $urandom_range(0, 3) != 0);
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL random_vec c=%0d got %h exp %h", c, act, exp_vec()); end
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 0, 0, 1);
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL drain_vec c=%0d got %h exp %h", c, act, exp_vec()); end
      tick();
    end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", rsp_valid); end
  endtask

  task automatic test_rst_mid();
    for (int c = 0; c < 4; c++) begin
      drive(c < 2, 0, 5'(c + 1), 64'd0, 0);
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL rstmid_vec c=%0d got %h exp %h", c, act, exp_vec()); end
      tick();
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rstmid_full got %b exp 1", rsp_valid); end
    rst = 1;
    drive(0, 0, 0, 0, 1);
    checks++;
    if (act !== 68'd0) begin errors++; $display("FAIL rstmid_during got %h exp 0", act); end
    tick();
    rst = 0;
    drive(0, 0, 0, 0, 1);
    checks++;
    if ({rsp_valid, mem_sel, mem_adr} !== {1'b0, 1'b1, 5'd0}) begin errors++; $display("FAIL rstmid_after got v=%b sel=%b adr=%0d exp 0 1 0", rsp_valid, mem_sel, mem_adr); end
    test_clear(10);
    rst = 1;
    drive(0, 0, 0, 0, 1);
    tick();
    test_clear(DEPTH);
  endtask

  initial begin
    foreach (ram[i]) ram[i] = {$urandom, $urandom};
    foreach (golden[i]) golden[i] = '0;
    test_reset();
    test_clear(DEPTH);
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_same_addr();
    test_random();
    test_rst_mid();
    test_directed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
